// File: rtl/mem_port_b_streamer.sv
// Sequential reader for data-memory port B: walks an address range and streams words valid/ready.
// Define STREAMER_WRAP_EN to loop over the range continuously until rst.
module mem_port_b_streamer #(
    parameter int unsigned ADDR_WIDTH   = 18,
    parameter int unsigned DATA_WIDTH   = 24,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    output logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] read_data_b,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned FcntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + READ_LATENCY + 3);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0] remain_q, remain_d;
    // Bit 0 marks the address register stage; bit READ_LATENCY lines up with read_data_b.
    logic [READ_LATENCY:0] tag_q, tag_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [FcntW-1:0]      fcnt_q, fcnt_d;

    logic [CntW-1:0]       in_flight;
    logic                  pop, fifo_wr, credit_ok, drained, issue;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_rem;

`ifdef STREAMER_WRAP_EN
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
    logic                  pass_done_q, pass_done_d;
`endif

    always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i <= READ_LATENCY; i++) begin
            in_flight = in_flight + CntW'(tag_q[i]);
        end
    end

    assign pop       = valid_out && ready_in;
    assign fifo_wr   = tag_q[READ_LATENCY];
    // Occupancy after this edge (FIFO + in flight) must stay within FIFO_DEPTH.
    assign credit_ok = (in_flight + CntW'(fcnt_q) + CntW'(1)) <= (CntW'(FIFO_DEPTH) + CntW'(pop));
    assign drained   = (in_flight == '0) && ((fcnt_q == '0) || ((fcnt_q == FcntW'(1)) && pop));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        remain_d    = remain_q;
        tag_d       = {tag_q[READ_LATENCY-1:0], 1'b0};
        issue       = 1'b0;
        cur_addr    = next_addr_q;
        cur_rem     = remain_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRun;
                    remain_d = word_count;
                    if (word_count != '0) begin
                        issue    = 1'b1;
                        cur_addr = base_addr;
                        cur_rem  = word_count;
                    end
                end
            end
            StRun: begin
                if (remain_q == '0) begin
                    state_d = drained ? StDone : StDrain;
                end else if (credit_ok) begin
                    issue = 1'b1;
                end
            end
            StDrain: begin
                if (drained) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (issue) begin
            addr_d   = cur_addr;
            tag_d[0] = 1'b1;
            if (cur_rem == ADDR_WIDTH'(1)) begin
`ifdef STREAMER_WRAP_EN
                next_addr_d = (state_q == StIdle) ? base_addr : base_q;
                remain_d    = (state_q == StIdle) ? word_count : count_q;
`else
                remain_d = '0;
                state_d  = StDrain;
`endif
            end else begin
                next_addr_d = cur_addr + ADDR_WIDTH'(1);
                remain_d    = cur_rem - ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (fifo_wr) begin
            fifo_mem_d[wr_ptr_q] = read_data_b;
            wr_ptr_d             = wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
        fcnt_d = fcnt_q + FcntW'(fifo_wr) - FcntW'(pop);
    end

`ifdef STREAMER_WRAP_EN
    // Words leave in issue order, so counting pops against the pass length finds pass ends.
    always_comb begin
        base_d      = base_q;
        count_d     = count_q;
        pass_cnt_d  = pass_cnt_q;
        pass_done_d = 1'b0;
        if (state_q == StIdle && start) begin
            base_d     = base_addr;
            count_d    = word_count;
            pass_cnt_d = '0;
        end else if (pop) begin
            if (pass_cnt_q == count_q - ADDR_WIDTH'(1)) begin
                pass_done_d = 1'b1;
                pass_cnt_d  = '0;
            end else begin
                pass_cnt_d = pass_cnt_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            count_q     <= '0;
            pass_cnt_q  <= '0;
            pass_done_q <= 1'b0;
        end else begin
            base_q      <= base_d;
            count_q     <= count_d;
            pass_cnt_q  <= pass_cnt_d;
            pass_done_q <= pass_done_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            next_addr_q <= '0;
            remain_q    <= '0;
            tag_q       <= '0;
            fifo_mem_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            remain_q    <= remain_d;
            tag_q       <= tag_d;
            fifo_mem_q  <= fifo_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign address_b = addr_q;
    assign data_out  = fifo_mem_q[rd_ptr_q];
    assign valid_out = (fcnt_q != '0);
    assign busy      = (state_q == StRun) || (state_q == StDrain);
`ifdef STREAMER_WRAP_EN
    assign done      = (state_q == StDone) || pass_done_q;
`else
    assign done      = (state_q == StDone);
`endif

endmodule

// File: tb/tb_mem_port_b_streamer.sv
// Bench for mem_port_b_streamer: latency-L memory model, expected streams computed from
// base + i addressing and cycle arithmetic.
`timescale 1ns/1ps
module tb_mem_port_b_streamer;
    localparam int unsigned AW = 18;
    localparam int unsigned DW = 24;
    localparam int unsigned L  = 1;
    localparam int unsigned D  = 4;

    logic          clk = 1'b0;
    logic          rst, start, ready_in;
    logic [AW-1:0] base_addr, word_count, address_b;
    logic [DW-1:0] read_data_b, data_out;
    logic          valid_out, busy, done;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] acc_q[$];
    int            acc_cyc_q[$];
    logic [AW-1:0] addr_q[$];
    int            addr_cyc_q[$];
    int            done_cyc_q[$];
    int            first_busy, last_busy, max_out, unstable, valid_after_rst;
    logic [AW+DW+2:0] rst_snap;

    always #5 clk = ~clk;

    mem_port_b_streamer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(L),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .address_b  (address_b),
        .read_data_b(read_data_b),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[5:0], a} ^ 24'hA5C3F0;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int i);
        logic [AW-1:0] r;
        r = base + AW'(i);
        return r;
    endfunction

    // Synchronous memory: read_data_b in cycle c reflects address_b of cycle c-L.
    logic [DW-1:0] rd_pipe [L];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_word(address_b);
        for (int i = 1; i < int'(L); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign read_data_b = rd_pipe[L-1];

    // mode: 0 ready high, 1 alternating, 2 random, 3 low until cycle 12.
    task automatic do_xfer(input logic [AW-1:0] base, input logic [AW-1:0] cnt, input int mode,
                           input int max_cycles, input logic [63:0] poke_mask,
                           input int rst_cyc, input bit stop_on_done);
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] held;
        bit            stalled;
        int            outstanding;
        acc_q.delete(); acc_cyc_q.delete(); addr_q.delete(); addr_cyc_q.delete();
        done_cyc_q.delete();
        first_busy = -1; last_busy = -1; max_out = 0; unstable = 0; valid_after_rst = 0;
        rst_snap = '1; stalled = 1'b0; held = '0;
        prev_addr = address_b;
        base_addr = base; word_count = cnt; start = 1'b1; ready_in = 1'b1;
        @(posedge clk); #1;
        for (int j = 1; j <= max_cycles; j++) begin
            if (address_b !== prev_addr) begin
                addr_q.push_back(address_b);
                addr_cyc_q.push_back(j);
            end
            prev_addr = address_b;
            if (busy === 1'b1) begin
                if (first_busy < 0) first_busy = j;
                last_busy = j;
            end
            if (done === 1'b1) done_cyc_q.push_back(j);
            if (stalled && (valid_out !== 1'b1 || data_out !== held)) unstable++;
            if (rst_cyc >= 0 && j == rst_cyc + 1)
                rst_snap = {address_b, data_out, valid_out, busy, done};
            if (rst_cyc >= 0 && j > rst_cyc && valid_out === 1'b1) valid_after_rst++;
            outstanding = addr_q.size() - acc_q.size();
            if (outstanding > max_out) max_out = outstanding;

            start = (j < 64) ? poke_mask[j] : 1'b0;
            if (start) begin
                base_addr  = 18'h02000;
                word_count = 18'd5;
            end
            rst = (j == rst_cyc);
            case (mode)
                1: ready_in = j[0];
                2: ready_in = ($urandom_range(1) == 1);
                3: ready_in = (j >= 12);
                default: ready_in = 1'b1;
            endcase
            if (rst) ready_in = 1'b0;
            if (valid_out === 1'b1 && ready_in) begin
                acc_q.push_back(data_out);
                acc_cyc_q.push_back(j);
            end
            stalled = (valid_out === 1'b1) && !ready_in && !rst;
            held = data_out;
            if (stop_on_done && done_cyc_q.size() > 0 && j >= done_cyc_q[0] + 2) break;
            @(posedge clk); #1;
        end
        start = 1'b0; rst = 1'b0; ready_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready_in = 1'b1; base_addr = '0; word_count = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (address_b !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", address_b); end
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({address_b, data_out, valid_out, busy, done} !== '0) begin
                errors++;
                $display("FAIL idle[%0d]: got addr=%h data=%h v=%b b=%b d=%b want all 0",
                         i, address_b, data_out, valid_out, busy, done);
            end
        end
    endtask

    task automatic test_stream();
        do_xfer(18'h00010, 18'd8, 0, 40, '0, -1, 1'b1);
        checks++;
        if (acc_q.size() != 8) begin errors++; $display("FAIL stream_count: got %0d want 8", acc_q.size()); end
        for (int i = 0; i < acc_q.size() && i < 8; i++) begin
            checks++;
            if (acc_q[i] !== mem_word(exp_addr(18'h10, i))) begin
                errors++;
                $display("FAIL stream_data[%0d]: got %h want %h", i, acc_q[i], mem_word(exp_addr(18'h10, i)));
            end
            checks++;
            if (acc_cyc_q[i] != 3 + i) begin
                errors++;
                $display("FAIL stream_cycle[%0d]: got T+%0d want T+%0d", i, acc_cyc_q[i], 3 + i);
            end
        end
        for (int i = 0; i < addr_q.size() && i < 8; i++) begin
            checks++;
            if (addr_q[i] !== exp_addr(18'h10, i)) begin
                errors++;
                $display("FAIL stream_addr[%0d]: got %h want %h", i, addr_q[i], exp_addr(18'h10, i));
            end
        end
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != 11) begin
            errors++;
            $display("FAIL stream_done: got %0d pulses first T+%0d want 1 at T+11",
                     done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1);
        end
        checks++;
        if (first_busy != 1 || last_busy != 10) begin
            errors++;
            $display("FAIL stream_busy: got T+%0d..T+%0d want T+1..T+10", first_busy, last_busy);
        end
    endtask

    task automatic test_backpressure();
        do_xfer(18'h00010, 18'd8, 1, 80, '0, -1, 1'b1);
        checks++;
        if (acc_q.size() != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", acc_q.size()); end
        for (int i = 0; i < acc_q.size() && i < 8; i++) begin
            checks++;
            if (acc_q[i] !== mem_word(exp_addr(18'h10, i))) begin
                errors++;
                $display("FAIL bp_data[%0d]: got %h want %h", i, acc_q[i], mem_word(exp_addr(18'h10, i)));
            end
        end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
        checks++;
        if (max_out > int'(D)) begin errors++; $display("FAIL bp_outstanding: got %0d want <= %0d", max_out, D); end
        checks++;
        if (done_cyc_q.size() != 1 || acc_cyc_q.size() == 0 ||
            done_cyc_q[0] != acc_cyc_q[acc_cyc_q.size()-1] + 1) begin
            errors++;
            $display("FAIL bp_done: got %0d pulses want 1 right after last accept", done_cyc_q.size());
        end
    endtask

    task automatic test_stall();
        do_xfer(18'h00300, 18'd8, 3, 60, '0, -1, 1'b1);
        checks++;
        if (max_out != int'(D)) begin errors++; $display("FAIL stall_outstanding: got %0d want %0d", max_out, D); end
        checks++;
        if (addr_cyc_q.size() < 5 || addr_cyc_q[3] != 4 || addr_cyc_q[4] != 13) begin
            errors++;
            $display("FAIL stall_resume: got issue4=T+%0d issue5=T+%0d want T+4 T+13",
                     (addr_cyc_q.size() > 3) ? addr_cyc_q[3] : -1,
                     (addr_cyc_q.size() > 4) ? addr_cyc_q[4] : -1);
        end
        for (int i = 0; i < acc_q.size() && i < 8; i++) begin
            checks++;
            if (acc_q[i] !== mem_word(exp_addr(18'h300, i))) begin
                errors++;
                $display("FAIL stall_data[%0d]: got %h want %h", i, acc_q[i], mem_word(exp_addr(18'h300, i)));
            end
        end
        checks++;
        if (acc_q.size() != 8) begin errors++; $display("FAIL stall_count: got %0d want 8", acc_q.size()); end
    endtask

    task automatic test_addr_wrap();
        logic [AW-1:0] exp [4];
        exp[0] = 18'h3FFFE; exp[1] = 18'h3FFFF; exp[2] = 18'h00000; exp[3] = 18'h00001;
        do_xfer(18'h3FFFE, 18'd4, 0, 30, '0, -1, 1'b1);
        checks++;
        if (addr_q.size() != 4) begin errors++; $display("FAIL wrap_addr_count: got %0d want 4", addr_q.size()); end
        for (int i = 0; i < addr_q.size() && i < 4; i++) begin
            checks++;
            if (addr_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL wrap_addr[%0d]: got %h want %h", i, addr_q[i], exp[i]);
            end
            checks++;
            if (i < acc_q.size() && acc_q[i] !== mem_word(exp[i])) begin
                errors++;
                $display("FAIL wrap_data[%0d]: got %h want %h", i, acc_q[i], mem_word(exp[i]));
            end
        end
    endtask

    task automatic test_zero_count();
        do_xfer(18'h00555, 18'd0, 0, 20, '0, -1, 1'b1);
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != 2) begin
            errors++;
            $display("FAIL zero_done: got %0d pulses first T+%0d want 1 at T+2",
                     done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1);
        end
        checks++;
        if (acc_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL zero_activity: got %0d words %0d addrs want 0 0", acc_q.size(), addr_q.size());
        end
        checks++;
        if (first_busy != 1 || last_busy != 1) begin
            errors++;
            $display("FAIL zero_busy: got T+%0d..T+%0d want T+1..T+1", first_busy, last_busy);
        end
    endtask

    task automatic test_start_ignored();
        logic [63:0] m;
        m = '0; m[3] = 1'b1; m[7] = 1'b1; m[9] = 1'b1;
        do_xfer(18'h00100, 18'd6, 0, 40, m, -1, 1'b1);
        checks++;
        if (addr_q.size() != 6) begin errors++; $display("FAIL ign_addr_count: got %0d want 6", addr_q.size()); end
        for (int i = 0; i < acc_q.size() && i < 6; i++) begin
            checks++;
            if (acc_q[i] !== mem_word(exp_addr(18'h100, i))) begin
                errors++;
                $display("FAIL ign_data[%0d]: got %h want %h", i, acc_q[i], mem_word(exp_addr(18'h100, i)));
            end
        end
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != 9 || last_busy != 8) begin
            errors++;
            $display("FAIL ign_done: got %0d pulses last_busy T+%0d want 1 pulse at T+9 busy to T+8",
                     done_cyc_q.size(), last_busy);
        end
    endtask

    task automatic test_reset_mid();
        do_xfer(18'h00040, 18'd8, 0, 20, '0, 6, 1'b1);
        checks++;
        if (acc_q.size() != 3) begin errors++; $display("FAIL rstmid_count: got %0d want 3", acc_q.size()); end
        checks++;
        if (rst_snap !== '0) begin errors++; $display("FAIL rstmid_outputs: got %h want 0", rst_snap); end
        checks++;
        if (done_cyc_q.size() != 0) begin
            errors++; $display("FAIL rstmid_done: got %0d pulses want 0", done_cyc_q.size());
        end
        checks++;
        if (valid_after_rst != 0 || last_busy != 6) begin
            errors++;
            $display("FAIL rstmid_quiet: got %0d valid cycles last_busy T+%0d want 0 and T+6",
                     valid_after_rst, last_busy);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] base, cnt;
        for (int r = 0; r < 4; r++) begin
            cnt  = AW'($urandom_range(12, 1));
            base = AW'($urandom);
            while (base == address_b) base = AW'($urandom);
            do_xfer(base, cnt, 2, 400, '0, -1, 1'b1);
            checks++;
            if (acc_q.size() != int'(cnt)) begin
                errors++; $display("FAIL rand%0d_count: got %0d want %0d", r, acc_q.size(), cnt);
            end
            for (int i = 0; i < acc_q.size() && i < int'(cnt); i++) begin
                checks++;
                if (acc_q[i] !== mem_word(exp_addr(base, i))) begin
                    errors++;
                    $display("FAIL rand%0d_data[%0d]: got %h want %h", r, i, acc_q[i],
                             mem_word(exp_addr(base, i)));
                end
            end
            checks++;
            if (unstable != 0 || max_out > int'(D)) begin
                errors++;
                $display("FAIL rand%0d_flow: got %0d changes max %0d outstanding want 0 and <= %0d",
                         r, unstable, max_out, D);
            end
            checks++;
            if (done_cyc_q.size() != 1 || acc_cyc_q.size() == 0 ||
                done_cyc_q[0] != acc_cyc_q[acc_cyc_q.size()-1] + 1) begin
                errors++;
                $display("FAIL rand%0d_done: got %0d pulses want 1 right after last accept",
                         r, done_cyc_q.size());
            end
        end
    endtask

    task automatic test_wrap_mode();
        do_xfer(18'h00020, 18'd3, 0, 20, '0, -1, 1'b0);
        checks++;
        if (acc_q.size() != 18) begin errors++; $display("FAIL loop_count: got %0d want 18", acc_q.size()); end
        for (int i = 0; i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== mem_word(exp_addr(18'h20, i % 3)) || acc_cyc_q[i] != 3 + i) begin
                errors++;
                $display("FAIL loop_word[%0d]: got %h at T+%0d want %h at T+%0d", i, acc_q[i],
                         acc_cyc_q[i], mem_word(exp_addr(18'h20, i % 3)), 3 + i);
            end
        end
        checks++;
        if (done_cyc_q.size() != 5) begin errors++; $display("FAIL loop_done_count: got %0d want 5", done_cyc_q.size()); end
        for (int k = 0; k < done_cyc_q.size(); k++) begin
            checks++;
            if (done_cyc_q[k] != 6 + 3 * k) begin
                errors++; $display("FAIL loop_done[%0d]: got T+%0d want T+%0d", k, done_cyc_q[k], 6 + 3 * k);
            end
        end
        checks++;
        if (last_busy != 20) begin errors++; $display("FAIL loop_busy: got T+%0d want T+20", last_busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid_out !== 1'b0) begin
            errors++; $display("FAIL loop_stop: got busy=%b valid=%b want 0 0", busy, valid_out);
        end
    endtask

    initial begin
        test_reset();
`ifdef STREAMER_WRAP_EN
        test_wrap_mode();
`else
        test_stream();
        test_backpressure();
        test_stall();
        test_addr_wrap();
        test_zero_count();
        test_start_ignored();
        test_reset_mid();
        test_random();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
